// File: rtl/dfe_prl_pkg.sv
// Shared definitions for the parallel (look-ahead) PAM-4 DFE.
//   - PAM-4 decision levels and slicer thresholds
//   - tap-load FSM state encoding
//   - Q0.7 fractional-bit count for coefficient products
//   - helpers: symbol-to-level lookup and 12-bit to 8-bit saturation
package dfe_prl_pkg;

  localparam int SEP_DEFAULT = 56;

  localparam logic signed [7:0] L0 = -8'sd84;
  localparam logic signed [7:0] L1 = -8'sd28;
  localparam logic signed [7:0] L2 =  8'sd28;
  localparam logic signed [7:0] L3 =  8'sd84;

  localparam logic signed [7:0] TH_LO  = -8'sd56;
  localparam logic signed [7:0] TH_MID =  8'sd0;
  localparam logic signed [7:0] TH_HI  =  8'sd56;

  localparam int FRAC_BITS = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } load_state_e;

  // Map a 2-bit decision symbol (0..3) to its signed PAM-4 level.
  function automatic logic signed [7:0] level_of(input logic [1:0] sym);
    logic signed [7:0] lvl;
    case (sym)
      2'd0:    lvl = L0;
      2'd1:    lvl = L1;
      2'd2:    lvl = L2;
      2'd3:    lvl = L3;
      default: lvl = L0;
    endcase
    return lvl;
  endfunction

  // Clamp a 12-bit signed equalised value into the 8-bit sample range.
  function automatic logic signed [7:0] sat8(input logic signed [11:0] v);
    logic signed [7:0] r;
    if (v > 12'sd127) begin
      r = 8'sd127;
    end else if (v < -12'sd128) begin
      r = -8'sd128;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dfe_prl_pam4_slicer.sv
// Combinational PAM-4 slicer.
//   sample_i : 8-bit signed equalised sample
//   level_o  : decided level (L0..L3)
//   sym_o    : decided symbol index 0..3 (feeds the decision history)
// A sample sitting exactly on a threshold resolves to the upper level.
module pam4_slicer
  import dfe_prl_pkg::*;
(
  input  logic signed [7:0] sample_i,
  output logic signed [7:0] level_o,
  output logic        [1:0] sym_o
);

  // Threshold comparison, upper level wins on equality.
  always_comb begin
    sym_o = 2'd0;
    if (sample_i >= TH_HI) begin
      sym_o = 2'd3;
    end else if (sample_i >= TH_MID) begin
      sym_o = 2'd2;
    end else if (sample_i >= TH_LO) begin
      sym_o = 2'd1;
    end else begin
      sym_o = 2'd0;
    end
    level_o = level_of(sym_o);
  end

endmodule

// File: rtl/dfe_prl.sv
// Parallel (look-ahead) decision-feedback equaliser for PAM-4.
//   clk, reset        : clock, synchronous active-high reset
//   signal_in(_valid) : signed noisy sample and its qualifier
//   signal_out(_valid): decided level, one cycle after a valid sample
//   load_mem          : request to load postcursor taps from mem_data
//   done_wait         : taps loaded (sticky until reset)
//   location          : external word index, not used internally
//   mem_data          : coefficient word, byte k = tap h[k] in Q0.7
// Every combination of past decisions gets its own precomputed candidate;
// the real decision history only drives the final mux, so the feedback
// loop is a mux plus slicer rather than multiply-accumulate.
module dfe_prl
  import dfe_prl_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 3,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int SYMBOL_SEPERATION     = 56
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [7:0]  signal_in,
  input  logic               signal_in_valid,
  output logic signed [7:0]  signal_out,
  output logic               signal_out_valid,
  input  logic               load_mem,
  output logic               done_wait,
  input  logic        [7:0]  location,
  input  logic        [63:0] mem_data
);

  localparam int NP = PULSE_RESPONSE_LENGTH - 1;  // postcursor taps
  localparam int NC = 1 << (2 * NP);              // 4^NP candidates

  if (PULSE_RESPONSE_LENGTH < 2 || PULSE_RESPONSE_LENGTH > 4 ||
      SIGNAL_RESOLUTION != 8 || SYMBOL_SEPERATION != SEP_DEFAULT) begin : g_bad_param
    $error("dfe_prl: unsupported parameter combination");
  end

  load_state_e       state_q, state_d;
  logic              done_q;
  logic signed [7:0] taps_q     [NP];
  logic        [1:0] hist_sym_q [NP];   // index 0 is d[n-1]
  logic     [NP-1:0] hist_vld_q;        // empty slot contributes no ISI
  logic signed [7:0] out_q;
  logic              out_vld_q;

  logic signed [11:0] term_s [NP][4];
  logic signed [7:0]  cand_s [NC];
  logic [2*NP-1:0]    sel_s;
  logic signed [7:0]  cand_sel_s;
  logic signed [7:0]  slice_level_s;
  logic        [1:0]  slice_sym_s;
  logic               unused_s;

  assign unused_s = ^{location, mem_data[7:0], mem_data[63:8*PULSE_RESPONSE_LENGTH]};

  // Per tap and per possible past level: (h[k]*level) >>> 7, zero for empty history.
  always_comb begin
    logic signed [15:0] prod;
    logic signed [15:0] shifted;
    prod    = 16'sd0;
    shifted = 16'sd0;
    for (int k = 0; k < NP; k++) begin
      for (int j = 0; j < 4; j++) begin
        prod    = taps_q[k] * level_of(2'(j));
        shifted = prod >>> FRAC_BITS;
        term_s[k][j] = hist_vld_q[k] ? shifted[11:0] : 12'sd0;
      end
    end
  end

  // One saturated candidate per decision-history combination.
  always_comb begin
    logic signed [11:0] acc;
    logic        [1:0]  j;
    acc = 12'sd0;
    j   = 2'd0;
    for (int c = 0; c < NC; c++) begin
      acc = {{4{signal_in[7]}}, signal_in};
      for (int k = 0; k < NP; k++) begin
        j   = 2'((c >> (2 * k)) & 3);
        acc = acc - term_s[k][j];
      end
      cand_s[c] = sat8(acc);
    end
  end

  // Real history selects the candidate; slot k occupies select bits 2k+1:2k.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < NP; k++) begin
      sel_s[2*k +: 2] = hist_sym_q[k];
    end
    cand_sel_s = cand_s[sel_s];
  end

  pam4_slicer u_slicer (
    .sample_i (cand_sel_s),
    .level_o  (slice_level_s),
    .sym_o    (slice_sym_s)
  );

  // Tap-load FSM next state; DONE is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_mem) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, taps, decision history and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      out_q      <= 8'sd0;
      out_vld_q  <= 1'b0;
      hist_vld_q <= '0;
      for (int k = 0; k < NP; k++) begin
        taps_q[k]     <= 8'sd0;
        hist_sym_q[k] <= 2'd0;
      end
    end else begin
      state_q   <= state_d;
      done_q    <= (state_d == ST_DONE);
      out_vld_q <= signal_in_valid;
      // A sample in the capture cycle still sees the old taps.
      if (state_q == ST_CAPTURE) begin
        for (int k = 0; k < NP; k++) begin
          taps_q[k] <= $signed(mem_data[8*(k+1) +: 8]);
        end
      end
      if (signal_in_valid) begin
        out_q         <= slice_level_s;
        hist_sym_q[0] <= slice_sym_s;
        hist_vld_q[0] <= 1'b1;
        for (int k = 1; k < NP; k++) begin
          hist_sym_q[k] <= hist_sym_q[k-1];
          hist_vld_q[k] <= hist_vld_q[k-1];
        end
      end
    end
  end

  assign signal_out       = out_q;
  assign signal_out_valid = out_vld_q;
  assign done_wait        = done_q;

endmodule

// File: tb/tb_dfe_prl.sv
// Directed self-checking bench for dfe_prl with hand-computed expectations.
module tb_dfe_prl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [7:0]  signal_in = 8'sd0;
  logic               signal_in_valid = 1'b0;
  logic signed [7:0]  signal_out;
  logic               signal_out_valid;
  logic               load_mem = 1'b0;
  logic               done_wait;
  logic        [7:0]  location = 8'd0;
  logic        [63:0] mem_data = 64'd0;

  int pass_cnt = 0;
  int total_cnt = 0;

  dfe_prl dut (
    .clk              (clk),
    .reset            (reset),
    .signal_in        (signal_in),
    .signal_in_valid  (signal_in_valid),
    .signal_out       (signal_out),
    .signal_out_valid (signal_out_valid),
    .load_mem         (load_mem),
    .done_wait        (done_wait),
    .location         (location),
    .mem_data         (mem_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] x);
    signal_in       = x;
    signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int exp);
    check({tag, "_val"}, int'(signal_out), exp);
    check({tag, "_vld"}, int'(signal_out_valid), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [63:0] word, input string tag);
    mem_data = word;
    load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
    check({tag, "_done_wait"}, int'(done_wait), 0);
    tick();
    check({tag, "_done_capture"}, int'(done_wait), 0);
    tick();
    check({tag, "_done"}, int'(done_wait), 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out", int'(signal_out), 0);
    check("rst_vld", int'(signal_out_valid), 0);
    check("rst_done", int'(done_wait), 0);

    // Plain slicing before any load, including threshold edges
    send(8'sd100);  check_out("pre_100", 84);
    send(8'sd30);   check_out("pre_30", 28);
    send(-8'sd1);   check_out("pre_m1", -28);
    send(-8'sd56);  check_out("pre_m56", -28);
    send(-8'sd57);  check_out("pre_m57", -84);
    send(8'sd56);   check_out("pre_56", 84);
    send(8'sd0);    check_out("pre_0", 28);
    tick();
    check("hold_vld", int'(signal_out_valid), 0);
    check("hold_val", int'(signal_out), 28);

    // Two-tap load: h1=0.5, h2=0.125
    do_reset();
    do_load(64'h0000_0000_0010_4080, "ld2");
    send(8'sd84);  check_out("ld2_s1", 84);   // empty history
    send(8'sd84);  check_out("ld2_s2", 28);   // 84-42=42
    send(8'sd20);  check_out("ld2_s3", -28);  // 20-14-10=-4
    send(8'sd45);  check_out("ld2_s4", 84);   // 45+14-3=56, on threshold
    load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
    tick();
    check("ld2_done_sticky", int'(done_wait), 1);

    // ISI cancel with h1=0.5
    do_reset();
    do_load(64'h0000_0000_0000_4000, "isi");
    send(8'sd84);  check_out("isi_s1", 84);
    send(8'sd14);  check_out("isi_s2", -28);  // 14-42=-28

    // Saturation with h1=127/128
    do_reset();
    do_load(64'h0000_0000_0000_7F00, "sat");
    send(-8'sd84); check_out("sat_s1", -84);
    send(8'sd127); check_out("sat_s2", 84);   // 127+84 clamps to 127

    // Gapped valid: history frozen over idle cycles
    do_reset();
    do_load(64'h0000_0000_0000_4000, "gap");
    send(8'sd84);  check_out("gap_s1", 84);
    tick();
    check("gap_idle1_vld", int'(signal_out_valid), 0);
    tick();
    tick();
    check("gap_idle3_vld", int'(signal_out_valid), 0);
    check("gap_idle3_hold", int'(signal_out), 84);
    send(8'sd14);  check_out("gap_s2", -28);

    // Sample coinciding with tap capture uses the old taps
    do_reset();
    send(8'sd84);  check_out("cap_s1", 84);
    mem_data = 64'h0000_0000_0000_4000;
    load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
    tick();
    send(8'sd14);  check_out("cap_s2", 28);   // taps still zero
    check("cap_done", int'(done_wait), 1);
    send(8'sd0);   check_out("cap_s3", -28);  // 0-14=-14

    // Reset mid-load aborts; no taps without a new request
    do_reset();
    mem_data = 64'h0000_0000_0000_4000;
    load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("abort_done", int'(done_wait), 0);
    send(8'sd84);  check_out("abort_s1", 84);
    send(8'sd14);  check_out("abort_s2", 28);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
